// File: rtl/rgb_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_pkg
//  Description : Shared mode encoding and the effective-duty function for the
//                RGB PWM controller.
//  Revision    : 1.0  initial release
// ============================================================================
package rgb_pwm_pkg;

    // Widest duty resolution the eff_duty helper supports.
    localparam int DUTY_MAX_BITS = 16;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC  = 2'b00;
    localparam mode_t MODE_BLINK   = 2'b01;
    localparam mode_t MODE_BREATHE = 2'b10;
    localparam mode_t MODE_OFF     = 2'b11;

    // Effective duty for one channel.
    // Callers zero-extend to DUTY_MAX_BITS and keep the low w bits of the
    // result. In breathe mode the result is the upper w bits of the 2w-bit
    // product duty*env.
    function automatic logic [DUTY_MAX_BITS-1:0] eff_duty(
        input logic [DUTY_MAX_BITS-1:0] duty,
        input logic [DUTY_MAX_BITS-1:0] env,
        input mode_t                    mode,
        input logic                     phase_on,
        input int unsigned              w
    );
        logic [2*DUTY_MAX_BITS-1:0] prod;
        prod     = {{DUTY_MAX_BITS{1'b0}}, duty} * {{DUTY_MAX_BITS{1'b0}}, env};
        eff_duty = '0;
        case (mode)
            MODE_STATIC:  eff_duty = duty;
            MODE_BLINK:   eff_duty = phase_on ? duty : '0;
            MODE_BREATHE: eff_duty = DUTY_MAX_BITS'(prod >> w);
            default:      eff_duty = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_chan.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_chan
//  Description : One PWM channel: registered compare of the shared period
//                counter against the channel's effective duty.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS-1:0] eff,
    output logic                pwm
);

    // Output is high while the counter is below the duty; eff=0 never fires,
    // eff=MAX covers every count 0..MAX-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < eff);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_ctrl
//  Description : N-channel PWM generator with static, blink and breathe modes.
//                Configuration is taken over valid/ready into shadow registers
//                and applied only at a PWM period boundary.
//                Build option RGB_PWM_SB_DRV_EN: drive the pads through the
//                iCE40 SB_RGBA_DRV current driver (needs N_CH = 3); otherwise
//                LED_RGB is the inverted PWM (active-low pins).
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int N_CH          = 3,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 48,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [N_CH*PWM_BITS-1:0] cfg_duty,
    input  logic [1:0]               cfg_mode,
    output logic [N_CH-1:0]          pwm,
    output logic                     period_start,
    output logic [N_CH-1:0]          LED_RGB
);

    localparam int c_presc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_blink_w = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    localparam logic [PWM_BITS-1:0]  c_max        = '1;
    localparam logic [PWM_BITS-1:0]  c_cnt_last   = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_PERIODS - 1);

    logic [c_presc_w-1:0]     r_presc;
    logic [PWM_BITS-1:0]      r_cnt;
    logic                     r_period_start;
    logic                     r_pending;
    logic [N_CH*PWM_BITS-1:0] r_shadow_duty;
    mode_t                    r_shadow_mode;
    logic [N_CH*PWM_BITS-1:0] r_act_duty;
    mode_t                    r_act_mode;
    logic [c_blink_w-1:0]     r_blink_cnt;
    logic                     r_phase_on;
    logic [PWM_BITS-1:0]      r_env;
    logic                     r_env_down;

    logic w_tick;
    logic w_boundary;
    logic w_capture;
    logic w_apply;
    logic w_mode_change;

    assign w_tick        = (r_presc == c_presc_last);
    assign w_boundary    = w_tick && (r_cnt == c_cnt_last);
    assign cfg_ready     = ~r_pending;
    assign w_capture     = cfg_valid && cfg_ready;
    // Capture only happens while nothing is pending, so a capture coinciding
    // with a boundary is naturally deferred to the following boundary.
    assign w_apply       = w_boundary && r_pending;
    assign w_mode_change = w_apply && (r_shadow_mode != r_act_mode);
    assign period_start  = r_period_start;

    // Prescaler, period counter (0..MAX-1) and the registered wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_presc        <= w_tick ? '0 : r_presc + 1'b1;
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Handshake: capture into shadow, copy shadow to active at the boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= 1'b0;
            r_shadow_duty <= '0;
            r_shadow_mode <= MODE_OFF;
            r_act_duty    <= '0;
            r_act_mode    <= MODE_OFF;
        end else if (w_capture) begin
            r_shadow_duty <= cfg_duty;
            r_shadow_mode <= cfg_mode;
            r_pending     <= 1'b1;
        end else if (w_apply) begin
            r_act_duty <= r_shadow_duty;
            r_act_mode <= r_shadow_mode;
            r_pending  <= 1'b0;
        end
    end

    // Blink phase toggles every BLINK_PERIODS boundaries; restarts on a mode change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (w_mode_change) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (w_boundary) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= '0;
                r_phase_on  <= ~r_phase_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Breathe envelope: triangle 0..MAX..0 stepping once per boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_env      <= '0;
            r_env_down <= 1'b0;
        end else if (w_mode_change) begin
            r_env      <= '0;
            r_env_down <= 1'b0;
        end else if (w_boundary) begin
            if (!r_env_down) begin
                if (r_env == c_max) begin
                    r_env      <= c_cnt_last;
                    r_env_down <= 1'b1;
                end else begin
                    r_env <= r_env + 1'b1;
                end
            end else begin
                if (r_env == '0) begin
                    r_env      <= PWM_BITS'(1);
                    r_env_down <= 1'b0;
                end else begin
                    r_env <= r_env - 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic [PWM_BITS-1:0] w_eff;

        assign w_eff = PWM_BITS'(eff_duty(
            DUTY_MAX_BITS'(r_act_duty[i*PWM_BITS +: PWM_BITS]),
            DUTY_MAX_BITS'(r_env),
            r_act_mode,
            r_phase_on,
            PWM_BITS));

        rgb_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .cnt (r_cnt),
            .eff (w_eff),
            .pwm (pwm[i])
        );
    end

`ifdef RGB_PWM_SB_DRV_EN
    // iCE40 constant-current RGB driver; this build requires N_CH = 3.
    SB_RGBA_DRV #(
        .CURRENT_MODE ("0b1"),
        .RGB0_CURRENT ("0b000001"),
        .RGB1_CURRENT ("0b000111"),
        .RGB2_CURRENT ("0b000111")
    ) u_rgb_drv (
        .CURREN   (1'b1),
        .RGBLEDEN (1'b1),
        .RGB0PWM  (pwm[0]),
        .RGB1PWM  (pwm[1]),
        .RGB2PWM  (pwm[2]),
        .RGB0     (LED_RGB[0]),
        .RGB1     (LED_RGB[1]),
        .RGB2     (LED_RGB[2])
    );
`else
    // Direct pin drive, LEDs are active-low.
    assign LED_RGB = ~pwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_pwm_ctrl
//  Description : Self-checking bench for rgb_pwm_ctrl (W=4, PRESCALE=2,
//                BLINK_PERIODS=2). A period-level reference model predicts
//                per-period high counts and the handshake state.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_pwm_ctrl;

    localparam int N     = 3;
    localparam int W     = 4;
    localparam int MAXV  = 15;
    localparam int PRE   = 2;
    localparam int BLINK = 2;
    localparam int PER   = MAXV * PRE;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [N*W-1:0] cfg_duty;
    logic [1:0]     cfg_mode;
    logic [N-1:0]   pwm;
    logic           period_start;
    logic [N-1:0]   LED_RGB;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (period granularity).
    int act_mode;
    int act_duty [N];
    int k;
    int pend;
    int pend_mode;
    int pend_duty [N];
    int pend_delay;

    rgb_pwm_ctrl #(
        .N_CH          (N),
        .PWM_BITS      (W),
        .PRESCALE      (PRE),
        .BLINK_PERIODS (BLINK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_duty     (cfg_duty),
        .cfg_mode     (cfg_mode),
        .pwm          (pwm),
        .period_start (period_start),
        .LED_RGB      (LED_RGB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Expected effective duty of a channel for the current period.
    function automatic int exp_eff(input int ch);
        int d;
        int m;
        int env;
        d = act_duty[ch];
        case (act_mode)
            0: return d;
            1: return (((k / BLINK) % 2) == 0) ? d : 0;
            2: begin
                m   = k % (2 * MAXV);
                env = (m <= MAXV) ? m : (2 * MAXV - m);
                return (d * env) / (MAXV + 1);
            end
            default: return 0;
        endcase
    endfunction

    function automatic void model_boundary();
        if (pend != 0 && pend_delay == 0) begin
            if (pend_mode != act_mode) k = 0;
            else k = k + 1;
            act_mode = pend_mode;
            for (int c = 0; c < N; c++) act_duty[c] = pend_duty[c];
            pend = 0;
        end else begin
            k = k + 1;
            if (pend != 0) pend_delay = pend_delay - 1;
        end
    endfunction

    task automatic issue(input int m, input logic [N*W-1:0] d, input int j);
        cfg_valid = 1'b1;
        cfg_mode  = 2'(m);
        cfg_duty  = d;
        if (pend == 0) begin
            pend       = 1;
            pend_mode  = m;
            for (int c = 0; c < N; c++) pend_duty[c] = int'(d[c*W +: W]);
            pend_delay = (j == PER - 1) ? 1 : 0;
        end
    endtask

    // One PWM period, sampled on falling edges right after a period_start.
    task automatic run_period(input int rq1, input int m1, input logic [N*W-1:0] d1,
                              input int rq2, input int m2, input logic [N*W-1:0] d2);
        int e [N];
        int hi [N];
        int lo [N];
        for (int c = 0; c < N; c++) begin
            e[c]  = exp_eff(c);
            hi[c] = 0;
            lo[c] = 0;
        end
        for (int j = 1; j <= PER; j++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            for (int c = 0; c < N; c++) begin
                hi[c] += int'(pwm[c]);
                lo[c] += int'(!LED_RGB[c]);
            end
            chk("period_start", 32'(period_start), 32'(j == PER));
            if (j == PER) model_boundary();
            chk("cfg_ready", 32'(cfg_ready), 32'(pend == 0));
            if (j == rq1) issue(m1, d1, j);
            else if (j == rq2) issue(m2, d2, j);
        end
        for (int c = 0; c < N; c++) begin
            chk("pwm_high_clocks", 32'(hi[c]), 32'(e[c] * PRE));
            chk("led_low_clocks", 32'(lo[c]), 32'(e[c] * PRE));
        end
    endtask

    initial begin
        int found;
        int r1, r2, mm1, mm2;
        logic [N*W-1:0] dd1, dd2;

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_duty  = '0;
        cfg_mode  = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_pwm", 32'(pwm), 32'(0));
        chk("reset_led", 32'(LED_RGB), 32'(7));
        chk("reset_ready", 32'(cfg_ready), 32'(1));
        chk("reset_period_start", 32'(period_start), 32'(0));
        rst = 1'b0;

        act_mode = 3;
        for (int c = 0; c < N; c++) begin
            act_duty[c]  = 0;
            pend_duty[c] = 0;
        end
        k = 0; pend = 0; pend_mode = 0; pend_delay = 0;

        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            @(negedge clk);
            if (period_start) found = 1;
        end
        chk("first_period_start", 32'(found), 32'(1));
        if (found == 0) begin
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
        model_boundary();

        // Static {ch2=15, ch1=8, ch0=0}, plus a request made while busy.
        run_period(5, 0, 12'hF80, 10, 0, 12'h333);
        run_period(-1, 0, '0, -1, 0, '0);
        // Blink request landing on the boundary cycle: applies one period later.
        run_period(PER - 1, 1, 12'hFFF, -1, 0, '0);
        for (int p = 0; p < 6; p++) run_period(-1, 0, '0, -1, 0, '0);
        // Breathe over more than a full triangle.
        run_period(3, 2, 12'hFFF, -1, 0, '0);
        for (int p = 0; p < 36; p++) run_period(-1, 0, '0, -1, 0, '0);

        // Randomized requests.
        for (int p = 0; p < 110; p++) begin
            r1 = -1; r2 = -1;
            mm1 = int'($urandom_range(3, 0));
            mm2 = int'($urandom_range(3, 0));
            dd1 = N*W'($urandom);
            dd2 = N*W'($urandom);
            if ($urandom_range(99, 0) < 30) r1 = int'($urandom_range(PER - 1, 1));
            if ($urandom_range(99, 0) < 25) r2 = int'($urandom_range(PER - 1, 1));
            if (r2 == r1) r2 = -1;
            run_period(r1, mm1, dd1, r2, mm2, dd2);
        end

        // Asynchronous reset while all outputs are high.
        run_period(4, 0, 12'hFFF, -1, 0, '0);
        run_period(-1, 0, '0, -1, 0, '0);
        @(negedge clk);
        chk("pre_reset_pwm", 32'(pwm), 32'(7));
        #2 rst = 1'b1;
        #1;
        chk("async_reset_pwm", 32'(pwm), 32'(0));
        chk("async_reset_led", 32'(LED_RGB), 32'(7));
        chk("async_reset_ready", 32'(cfg_ready), 32'(1));
        chk("async_reset_period_start", 32'(period_start), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 2 * PER + 5; t++) begin
            @(negedge clk);
            chk("post_reset_pwm", 32'(pwm), 32'(0));
            chk("post_reset_ready", 32'(cfg_ready), 32'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
